mod_n_updown_counter: RTL and testbench

Parametrised, runtime-configurable modulo counter: the successor to the fixed free-running up-counter. Adds a runtime terminal value, up/down/ping-pong/one-shot modes, synchronous load, count enable, and a registered terminal-count pulse. It serves as the general timing/sequencing counter for datapath and control blocks that previously instantiated the plain up-counter.

---
 rtl/cnt_pkg.sv | 21 ++
 rtl/cnt_prescaler.sv | 29 ++
 rtl/mod_n_updown_counter.sv | 152 +++++++++++++++
 tb/tb_mod_n_updown_counter.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnt_pkg.sv
// Shared types and reset values for the runtime-configurable modulo counter.
package cnt_pkg;

  typedef enum logic [1:0] {
    CNT_UP       = 2'd0,
    CNT_DOWN     = 2'd1,
    CNT_PINGPONG = 2'd2,
    CNT_ONESHOT  = 2'd3
  } cnt_mode_e;

  typedef enum logic [1:0] {
    OS_IDLE = 2'd0,
    OS_RUN  = 2'd1,
    OS_DONE = 2'd2
  } os_state_e;

  localparam logic      RST_TC       = 1'b0;
  localparam logic      RST_DIR      = 1'b1;
  localparam os_state_e RST_OS_STATE = OS_IDLE;

endpackage

// File: rtl/cnt_prescaler.sv
// Enable divider: raises tick on every PRESCALE-th enabled cycle, then restarts.
module cnt_prescaler #(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int            PW   = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] cnt_q;

  assign tick = en && (cnt_q == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= tick ? '0 : cnt_q + PW'(1);
    end
  end

endmodule

// File: rtl/mod_n_updown_counter.sv
// Modulo-(limit+1) counter with up/down/ping-pong/one-shot modes and a registered tc pulse.
// Optional enable prescaler is built only when CNT_PRESCALE_EN is defined.
module mod_n_updown_counter
  import cnt_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] limit,
  input  logic [1:0]       mode,
  input  logic             start,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             dir,
  output logic             busy
);

  logic [WIDTH-1:0] out_q, out_d;
  logic             tc_q, tc_d;
  logic             dir_q, dir_d;
  os_state_e        st_q, st_d;
  logic             step;
  cnt_mode_e        mode_e;
  logic [WIDTH:0]   out_inc;
  logic [WIDTH-1:0] clip_val;

`ifdef CNT_PRESCALE_EN
  cnt_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .clr  (load),
    .tick (step)
  );
`else
  localparam int unused_prescale = PRESCALE;
  assign step = en;
`endif

  assign mode_e   = cnt_mode_e'(mode);
  assign out_inc  = {1'b0, out_q} + (WIDTH+1)'(1);
  assign clip_val = (load_val > limit) ? limit : load_val;

  always_comb begin
    out_d = out_q;
    tc_d  = 1'b0;
    dir_d = dir_q;
    st_d  = st_q;
    if (load) begin
      out_d = clip_val;
    end else begin
      unique case (mode_e)
        CNT_UP: begin
          if (step) begin
            dir_d = 1'b1;
            if (out_q >= limit) begin
              out_d = '0;
              tc_d  = 1'b1;
            end else begin
              out_d = out_inc[WIDTH-1:0];
            end
          end
        end
        CNT_DOWN: begin
          if (step) begin
            dir_d = 1'b0;
            if (limit == '0 || out_q == '0) begin
              out_d = limit;
              tc_d  = 1'b1;
            end else if (out_q > limit) begin
              out_d = limit;
            end else begin
              out_d = out_q - WIDTH'(1);
            end
          end
        end
        CNT_PINGPONG: begin
          // An out-of-range value while rising counts as having reached the top.
          if (step) begin
            if (limit == '0) begin
              out_d = '0;
              tc_d  = 1'b1;
            end else if (dir_q && out_q >= limit) begin
              out_d = limit - WIDTH'(1);
              dir_d = 1'b0;
              tc_d  = 1'b1;
            end else if (!dir_q && out_q == '0) begin
              out_d = WIDTH'(1);
              dir_d = 1'b1;
              tc_d  = 1'b1;
            end else if (dir_q) begin
              out_d = out_inc[WIDTH-1:0];
            end else begin
              out_d = out_q - WIDTH'(1);
            end
          end
        end
        CNT_ONESHOT: begin
          case (st_q)
            OS_RUN: begin
              if (step) begin
                if (out_inc >= {1'b0, limit}) begin
                  out_d = limit;
                  tc_d  = 1'b1;
                  st_d  = OS_DONE;
                end else begin
                  out_d = out_inc[WIDTH-1:0];
                end
              end
            end
            default: begin
              if (start) begin
                out_d = '0;
                st_d  = OS_RUN;
              end
            end
          endcase
        end
      endcase
    end
    if (mode_e != CNT_ONESHOT) begin
      st_d = OS_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_q <= '0;
      tc_q  <= RST_TC;
      dir_q <= RST_DIR;
      st_q  <= RST_OS_STATE;
    end else begin
      out_q <= out_d;
      tc_q  <= tc_d;
      dir_q <= dir_d;
      st_q  <= st_d;
    end
  end

  assign out  = out_q;
  assign tc   = tc_q;
  assign dir  = dir_q;
  assign busy = (st_q == OS_RUN);

endmodule

// File: tb/tb_mod_n_updown_counter.sv
// Bench for mod_n_updown_counter: directed vectors plus a per-cycle behavioural model check.
module tb_mod_n_updown_counter;

  localparam int WIDTH    = 4;
  localparam int PRESCALE = 4;
`ifdef CNT_PRESCALE_EN
  localparam int STEP_CYC = PRESCALE;
  localparam int EXP12    = 3;
`else
  localparam int STEP_CYC = 1;
  localparam int EXP12    = 12;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             en, load, start;
  logic [WIDTH-1:0] load_val, limit;
  logic [1:0]       mode;
  logic [WIDTH-1:0] out;
  logic             tc, dir, busy;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_on = 1'b0;

  mod_n_updown_counter #(
    .WIDTH    (WIDTH),
    .PRESCALE (PRESCALE)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .load     (load),
    .load_val (load_val),
    .limit    (limit),
    .mode     (mode),
    .start    (start),
    .out      (out),
    .tc       (tc),
    .dir      (dir),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Behavioural model: st 0=idle, 1=running, 2=done
  typedef struct {
    int out;
    bit tc;
    bit dir;
    int st;
    int pre;
  } mstate_t;

  localparam mstate_t MS_RST = '{out: 0, tc: 1'b0, dir: 1'b1, st: 0, pre: 0};
  mstate_t ms = MS_RST;

  function automatic mstate_t mnext(mstate_t s, bit en_i, bit load_i, int lv, int lim, int md, bit start_i);
    mstate_t n;
    bit      stp;
    n    = s;
    n.tc = 1'b0;
    if (load_i) begin
      n.out = (lv < lim) ? lv : lim;
      n.pre = 0;
      if (md != 3) n.st = 0;
      return n;
    end
    stp = en_i;
`ifdef CNT_PRESCALE_EN
    if (en_i) begin
      if (s.pre == PRESCALE - 1) n.pre = 0;
      else begin
        n.pre = s.pre + 1;
        stp   = 1'b0;
      end
    end
`endif
    if (md == 3) begin
      if (s.st != 1) begin
        if (start_i) begin
          n.out = 0;
          n.st  = 1;
        end
      end else if (stp) begin
        if (s.out + 1 >= lim) begin
          n.out = lim;
          n.tc  = 1'b1;
          n.st  = 2;
        end else n.out = s.out + 1;
      end
      return n;
    end
    n.st = 0;
    if (!stp) return n;
    if (lim == 0) begin
      n.out = 0;
      n.tc  = 1'b1;
      if (md == 0) n.dir = 1'b1;
      if (md == 1) n.dir = 1'b0;
      return n;
    end
    case (md)
      0: begin
        n.dir = 1'b1;
        if (s.out >= lim) begin n.out = 0; n.tc = 1'b1; end
        else n.out = s.out + 1;
      end
      1: begin
        n.dir = 1'b0;
        if (s.out == 0) begin n.out = lim; n.tc = 1'b1; end
        else if (s.out > lim) n.out = lim;
        else n.out = s.out - 1;
      end
      default: begin
        if (s.dir && s.out >= lim) begin n.out = lim - 1; n.dir = 1'b0; n.tc = 1'b1; end
        else if (!s.dir && s.out == 0) begin n.out = 1; n.dir = 1'b1; n.tc = 1'b1; end
        else n.out = s.dir ? s.out + 1 : s.out - 1;
      end
    endcase
    return n;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) ms <= MS_RST;
    else      ms <= mnext(ms, en, load, int'(load_val), int'(limit), int'(mode), start);
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("model_out", 32'(out), 32'(ms.out));
      chk("model_tc", 32'(tc), 32'(ms.tc));
      chk("model_dir", 32'(dir), 32'(ms.dir));
      chk("model_busy", 32'(busy), 32'(ms.st == 1));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic step1();
    en = 1'b1;
    repeat (STEP_CYC) cyc();
    en = 1'b0;
  endtask

  task automatic rst_pulse();
    rst = 1'b0;
    cyc();
    rst = 1'b1;
  endtask

  initial begin
    int up_o[8]  = '{1, 2, 3, 4, 5, 0, 1, 2};
    int dn_o[4]  = '{2, 1, 0, 3};
    int pp_o[6]  = '{1, 2, 1, 0, 1, 2};
    int pp_t[6]  = '{0, 0, 1, 0, 1, 0};
    int pp_d[6]  = '{1, 1, 0, 0, 1, 1};
    int os_o[3]  = '{1, 2, 3};
    int os_b[3]  = '{1, 1, 0};
    int os_t[3]  = '{0, 0, 1};
    rst = 1'b0; en = 1'b0; load = 1'b0; start = 1'b0;
    load_val = '0; limit = 4'd5; mode = 2'd0;
    cyc();
    cyc();
    chk_on = 1'b1;
    chk("rst_out", 32'(out), 0);
    chk("rst_tc", 32'(tc), 0);
    chk("rst_dir", 32'(dir), 1);
    chk("rst_busy", 32'(busy), 0);
    rst = 1'b1;

    // UP, limit 5
    for (int i = 0; i < 8; i++) begin
      step1();
      chk("up_out", 32'(out), 32'(up_o[i]));
      chk("up_tc", 32'(tc), 32'(up_o[i] == 0));
    end

    // DOWN, limit 3, load clipped
    mode = 2'd1; limit = 4'd3; load = 1'b1; load_val = 4'd9;
    cyc();
    load = 1'b0;
    chk("dn_load_out", 32'(out), 3);
    chk("dn_load_tc", 32'(tc), 0);
    for (int i = 0; i < 4; i++) begin
      step1();
      chk("dn_out", 32'(out), 32'(dn_o[i]));
      chk("dn_tc", 32'(tc), 32'(dn_o[i] == 3));
      chk("dn_dir", 32'(dir), 0);
    end

    // PINGPONG, limit 2, from reset
    rst_pulse();
    mode = 2'd2; limit = 4'd2;
    for (int i = 0; i < 6; i++) begin
      step1();
      chk("pp_out", 32'(out), 32'(pp_o[i]));
      chk("pp_tc", 32'(tc), 32'(pp_t[i]));
      chk("pp_dir", 32'(dir), 32'(pp_d[i]));
    end

    // ONESHOT, limit 3
    mode = 2'd3; limit = 4'd3; start = 1'b1;
    cyc();
    start = 1'b0;
    chk("os_start_out", 32'(out), 0);
    chk("os_start_busy", 32'(busy), 1);
    for (int i = 0; i < 3; i++) begin
      step1();
      chk("os_out", 32'(out), 32'(os_o[i]));
      chk("os_busy", 32'(busy), 32'(os_b[i]));
      chk("os_tc", 32'(tc), 32'(os_t[i]));
    end
    for (int i = 0; i < 2; i++) begin
      step1();
      chk("os_hold_out", 32'(out), 3);
      chk("os_hold_tc", 32'(tc), 0);
    end
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("os_restart_out", 32'(out), 0);
    chk("os_restart_busy", 32'(busy), 1);
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("os_start_in_run", 32'(out), 0);
    step1();
    chk("os_run_step", 32'(out), 1);

    // UP to 6, then asynchronous reset mid-cycle
    mode = 2'd0; limit = 4'd9; load = 1'b1; load_val = 4'd5;
    cyc();
    load = 1'b0;
    chk("mode_chg_busy", 32'(busy), 0);
    step1();
    chk("up_mid_out", 32'(out), 6);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_out", 32'(out), 0);
    chk("async_rst_tc", 32'(tc), 0);
    chk("async_rst_dir", 32'(dir), 1);
    chk("async_rst_busy", 32'(busy), 0);
    rst = 1'b1;
    load = 1'b1; load_val = 4'd7; en = 1'b1;
    cyc();
    load = 1'b0; en = 1'b0;
    chk("load_wins_out", 32'(out), 7);
    chk("load_wins_tc", 32'(tc), 0);

    // Out above a lowered limit
    mode = 2'd1; limit = 4'd4;
    step1();
    chk("dn_above_out", 32'(out), 4);
    chk("dn_above_tc", 32'(tc), 0);
    mode = 2'd0; limit = 4'd2;
    step1();
    chk("up_above_out", 32'(out), 0);
    chk("up_above_tc", 32'(tc), 1);

    // limit 0
    limit = 4'd0;
    for (int i = 0; i < 2; i++) begin
      step1();
      chk("lim0_out", 32'(out), 0);
      chk("lim0_tc", 32'(tc), 1);
    end

    // Twelve enabled cycles from reset
    rst_pulse();
    mode = 2'd0; limit = 4'd15; en = 1'b1;
    repeat (12) cyc();
    en = 1'b0;
    chk("en12_out", 32'(out), 32'(EXP12));

    cyc();
    chk_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
